ts5n28_sram_sp_init: RTL and testbench

TS5N28_SRAM_SP_INIT -- requirements
Module: ts5n28_sram_sp_init

---
 rtl/ts5n28_sram_sp_init.sv | 159 +++++++++++++++
 tb/tb_ts5n28_sram_sp_init.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ts5n28_sram_sp_init.sv
// ---------------------------------------------------------------------------
// ts5n28_sram_sp_init
//
// Single-port synchronous SRAM model with a built-in initialisation sweep.
// Reset is asynchronous and active high. After RST is released, the block
// writes INIT_VALUE to every word, one word per clock, starting at word 0.
// When the last word has been written, READY rises and normal read/write
// access is accepted.
//
// Parameters:
//   BITS        data word width
//   WORD_DEPTH  number of words (2..4096, any value)
//   ADD_WIDTH   address width, 2**ADD_WIDTH >= WORD_DEPTH
//   INIT_VALUE  value loaded into every word by the init sweep
//
// Ports:
//   CLK    clock, rising edge
//   RST    asynchronous active-high reset
//   CEB    chip enable, active low
//   WEB    write enable, active low (0 = write, 1 = read)
//   BWEB   per-bit write enable, active low
//   A      word address
//   D      write data
//   Q      registered read data
//   QV     high for the one cycle in which Q carries a fresh read result
//   READY  high once the init sweep has completed
//
// Configuration macro:
//   TS5N28_SRAM_SP_INIT_QZERO_EN  when defined, Q returns to zero on every
//                                 cycle that follows a non-read cycle;
//                                 otherwise Q holds the last read value.
// ---------------------------------------------------------------------------
module ts5n28_sram_sp_init #(
    parameter int                BITS       = 80,
    parameter int                WORD_DEPTH = 32,
    parameter int                ADD_WIDTH  = 5,
    parameter logic [BITS-1:0]   INIT_VALUE = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CEB,
    input  logic                 WEB,
    input  logic [BITS-1:0]      BWEB,
    input  logic [ADD_WIDTH-1:0] A,
    input  logic [BITS-1:0]      D,
    output logic [BITS-1:0]      Q,
    output logic                 QV,
    output logic                 READY
);

    localparam int            CW        = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
    localparam logic [CW-1:0] LAST_WORD = CW'(WORD_DEPTH - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] q_q, q_d;
    logic            qv_q, qv_d;

    logic [BITS-1:0] mem [WORD_DEPTH];

    logic            addrInRange;
    logic [CW-1:0]   addrIdx;
    logic            isRead;
    logic            isWrite;
    logic            memWe;
    logic [CW-1:0]   memIdx;
    logic [BITS-1:0] memWdata;

    // The address is compared at full width so that addresses beyond the
    // array (possible when WORD_DEPTH is not a power of two) are recognised
    // before the index is narrowed to the counter width.
    assign addrInRange = (32'(A) < 32'(WORD_DEPTH));
    assign addrIdx     = CW'(A);

    // Access decode is only live in RUN; during INIT the external port is
    // ignored entirely. Out-of-range writes are dropped here, while
    // out-of-range reads still complete, returning zero with QV set.
    assign isRead  = (state_q == ST_RUN) && !CEB && WEB;
    assign isWrite = (state_q == ST_RUN) && !CEB && !WEB && addrInRange;

    // The array port is shared between the init sweep and normal writes.
    // A write merges new data into the stored word bit by bit, so BWEB
    // bits that are high keep the old contents. Writes are suppressed while
    // RST is held so that the array is only cleared by the sweep itself.
    always_comb begin
        memWe    = 1'b0;
        memIdx   = addrIdx;
        memWdata = (mem[addrIdx] & BWEB) | (D & ~BWEB);
        if (!RST) begin
            if (state_q == ST_INIT) begin
                memWe    = 1'b1;
                memIdx   = cnt_q;
                memWdata = INIT_VALUE;
            end else if (isWrite) begin
                memWe = 1'b1;
            end
        end
    end

    // The array has no reset; its contents persist until overwritten.
    always_ff @(posedge CLK) begin
        if (memWe) begin
            mem[memIdx] <= memWdata;
        end
    end

    // Next-state logic. INIT walks the counter through every word and
    // hands over to RUN after the cycle that writes the last word. RUN is
    // left only through RST. QV is a single-cycle pulse per read.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        qv_d    = 1'b0;
        if (state_q == ST_INIT) begin
            q_d = '0;
            if (cnt_q == LAST_WORD) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (isRead) begin
                q_d  = addrInRange ? mem[addrIdx] : '0;
                qv_d = 1'b1;
            end else begin
`ifdef TS5N28_SRAM_SP_INIT_QZERO_EN
                q_d = '0;
`else
                q_d = q_q;
`endif
            end
        end
    end

    // Control and output registers, asynchronously reset into INIT.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            q_q     <= '0;
            qv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
        end
    end

    assign Q     = q_q;
    assign QV    = qv_q;
    assign READY = (state_q == ST_RUN);

endmodule

// File: tb/tb_ts5n28_sram_sp_init.sv
// ---------------------------------------------------------------------------
// tb_ts5n28_sram_sp_init
//
// Directed bench for ts5n28_sram_sp_init. Two instances share the clock and
// the input bus: a default 32-word array with zero init value, and a
// 24-word array with a non-zero init value so that out-of-range addresses
// (24..31) and the init pattern itself can be exercised.
// ---------------------------------------------------------------------------
module tb_ts5n28_sram_sp_init;

    localparam logic [79:0] ONES   = {80{1'b1}};
    localparam logic [79:0] INIT24 = 80'h5A5A_5A5A_5A5A_5A5A_5A5A;

    logic        CLK;
    logic        RST;
    logic        CEB;
    logic        WEB;
    logic [79:0] BWEB;
    logic [4:0]  A;
    logic [79:0] D;

    logic [79:0] q32;
    logic        qv32;
    logic        ready32;
    logic [79:0] q24;
    logic        qv24;
    logic        ready24;

    int vectors;
    int miscompares;

    ts5n28_sram_sp_init #(
        .BITS       (80),
        .WORD_DEPTH (32),
        .ADD_WIDTH  (5),
        .INIT_VALUE ('0)
    ) dut32 (
        .CLK   (CLK),
        .RST   (RST),
        .CEB   (CEB),
        .WEB   (WEB),
        .BWEB  (BWEB),
        .A     (A),
        .D     (D),
        .Q     (q32),
        .QV    (qv32),
        .READY (ready32)
    );

    ts5n28_sram_sp_init #(
        .BITS       (80),
        .WORD_DEPTH (24),
        .ADD_WIDTH  (5),
        .INIT_VALUE (INIT24)
    ) dut24 (
        .CLK   (CLK),
        .RST   (RST),
        .CEB   (CEB),
        .WEB   (WEB),
        .BWEB  (BWEB),
        .A     (A),
        .D     (D),
        .Q     (q24),
        .QV    (qv24),
        .READY (ready24)
    );

    // Free-running 10-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drive one cycle of inputs, then sample 1 unit after the rising edge.
    task automatic applyStimulus(input logic ceb, input logic web, input logic [4:0] a,
                                 input logic [79:0] d, input logic [79:0] bweb);
        CEB  = ceb;
        WEB  = web;
        A    = a;
        D    = d;
        BWEB = bweb;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Hand-derived contents of the 24-word array after the RUN writes.
    function automatic logic [79:0] exp24(input int i);
        if (i >= 24)     return '0;
        else if (i == 1) return 80'hAB;
        else if (i == 3) return 80'h1234;
        else if (i == 5) return 80'h5A5A_5A5A_5A5A_5A5A_5AFF;
        else             return INIT24;
    endfunction

    // Count edges after a reset release; both arrays become ready at their
    // own depth, and port activity during INIT must have no effect.
    task automatic initSweep(input string tag, input logic junk);
        for (int i = 1; i <= 32; i++) begin
            if (junk && i <= 20) applyStimulus(1'b0, i[0], 5'(i), ONES, '0);
            else                 applyStimulus(1'b1, 1'b1, 5'd0, '0, ONES);
            checkOutput({tag, "_ready32"}, 80'(ready32), 80'(i >= 32));
            checkOutput({tag, "_ready24"}, 80'(ready24), 80'(i >= 24));
            if (i < 24) begin
                checkOutput({tag, "_qv24_init"}, 80'(qv24), 80'(0));
                checkOutput({tag, "_q24_init"}, q24, '0);
            end
            checkOutput({tag, "_qv32_init"}, 80'(qv32), 80'(0));
            checkOutput({tag, "_q32_init"}, q32, '0);
        end
    endtask

    initial begin
        logic [79:0] expIdle;
        vectors     = 0;
        miscompares = 0;
        RST  = 1'b1;
        CEB  = 1'b1;
        WEB  = 1'b1;
        BWEB = ONES;
        A    = '0;
        D    = '0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_ready", 80'(ready32), 80'(0));
        checkOutput("rst_q", q32, '0);
        checkOutput("rst_qv", 80'(qv32), 80'(0));
        RST = 1'b0;

        initSweep("boot", 1'b1);

        // Every address reads back its init value one cycle later.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 5'(i), '0, ONES);
            checkOutput("sweep_q32", q32, '0);
            checkOutput("sweep_qv32", 80'(qv32), 80'(1));
            checkOutput("sweep_q24", q24, (i < 24) ? INIT24 : 80'h0);
            checkOutput("sweep_qv24", 80'(qv24), 80'(1));
        end

        // Byte-masked write: only the low byte is enabled.
        applyStimulus(1'b0, 1'b0, 5'd5, ONES, {{72{1'b1}}, 8'h00});
        checkOutput("bweb_wr_qv", 80'(qv32), 80'(0));
        applyStimulus(1'b0, 1'b1, 5'd5, '0, ONES);
        checkOutput("bweb_q32", q32, 80'hFF);
        checkOutput("bweb_qv32", 80'(qv32), 80'(1));
        checkOutput("bweb_q24", q24, 80'h5A5A_5A5A_5A5A_5A5A_5AFF);

        // Read immediately after a write returns the new data.
        applyStimulus(1'b0, 1'b0, 5'd3, 80'h1234, '0);
        applyStimulus(1'b0, 1'b1, 5'd3, '0, ONES);
        checkOutput("raw_q32", q32, 80'h1234);
        checkOutput("raw_q24", q24, 80'h1234);

        // Read followed by an idle cycle: Q depends on the build, QV drops.
        applyStimulus(1'b0, 1'b0, 5'd1, 80'hAB, '0);
        applyStimulus(1'b0, 1'b1, 5'd1, '0, ONES);
        checkOutput("rd1_q32", q32, 80'hAB);
        applyStimulus(1'b1, 1'b1, 5'd1, '0, ONES);
`ifdef TS5N28_SRAM_SP_INIT_QZERO_EN
        expIdle = '0;
`else
        expIdle = 80'hAB;
`endif
        checkOutput("idle_q32", q32, expIdle);
        checkOutput("idle_qv32", 80'(qv32), 80'(0));
        checkOutput("idle_q24", q24, expIdle);

        // Address 30 lies outside the 24-word array but inside the 32-word one.
        applyStimulus(1'b0, 1'b0, 5'd30, ONES, '0);
        applyStimulus(1'b0, 1'b1, 5'd30, '0, ONES);
        checkOutput("oor_q24", q24, '0);
        checkOutput("oor_qv24", 80'(qv24), 80'(1));
        checkOutput("oor_q32", q32, ONES);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b0, 1'b1, 5'(i), '0, ONES);
            checkOutput("keep_q24", q24, exp24(i));
        end

        // Asynchronous reset in RUN right after a read.
        applyStimulus(1'b0, 1'b1, 5'd3, '0, ONES);
        checkOutput("pre_rst_q32", q32, 80'h1234);
        applyStimulus(1'b1, 1'b1, 5'd0, '0, ONES);
        RST = 1'b1;
        #1;
        checkOutput("arst_ready", 80'(ready32), 80'(0));
        checkOutput("arst_q", q32, '0);
        checkOutput("arst_qv", 80'(qv32), 80'(0));
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Ten INIT cycles, then reset again mid-sweep.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 5'd0, '0, ONES);
            checkOutput("part_ready", 80'(ready32), 80'(0));
        end
        RST = 1'b1;
        #1;
        checkOutput("mid_rst_ready", 80'(ready32), 80'(0));
        #1;
        RST = 1'b0;

        initSweep("reinit", 1'b0);

        // All words were rewritten by the new sweep.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b1, 5'(i), '0, ONES);
            checkOutput("reinit_q32", q32, '0);
            checkOutput("reinit_q24", q24, (i < 24) ? INIT24 : 80'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
